dense_argmax: RTL
=================

DENSE_ARGMAX -- requirements
Module: dense_argmax

Interface
REQ-001 Parameter NUM, default 128: number of FP32 scores in the dense output vector.
REQ-002 Parameter DATA_WIDTH, default 32: element width; only 32 (IEEE-754 single) is supported.
REQ-003 Parameter LANES, default 4: elements compared per cycle; NUM SHALL be a multiple of LANES.
REQ-004 Localparam IDXW = $clog2(NUM), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 data_i  input  DATA_WIDTH*NUM  dense result vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 valid_i  input  1  data_i is valid this cycle.
REQ-009 ready_o  output  1  block can accept a vector; high only in IDLE.
REQ-010 class_o  output  IDXW  index of the maximum element.
REQ-011 max_o  output  DATA_WIDTH  value of the maximum element.
REQ-012 valid_o  output  1  one-cycle pulse; class_o and max_o are valid.

Function
REQ-013 The block SHALL accept a vector when valid_i and ready_o are both high (the accept cycle) and register all of data_i internally.
REQ-014 FSM states: IDLE, SCAN, DONE; IDLE->SCAN on accept; SCAN->DONE after the last group; DONE->IDLE unconditionally after one cycle.
REQ-015 On accept: best value = element 0, best index = 0, group counter = 0.
REQ-016 In SCAN, each cycle SHALL compare group g (elements g*LANES .. g*LANES+LANES-1) against the running best in ascending index order, then increment g.
REQ-017 SCAN SHALL last exactly NUM/LANES cycles; valid_o SHALL assert in the DONE cycle, so accept-to-valid_o latency = NUM/LANES + 1 cycles.
REQ-018 class_o and max_o SHALL hold their last result until the next DONE.
REQ-019 Comparison rule: a candidate replaces the best only if it is strictly greater; ties keep the lower index.
REQ-020 Ordering SHALL be IEEE-754 total value order on non-NaN values; +0 and -0 compare equal.
REQ-021 A NaN candidate SHALL never replace the best; if element 0 is NaN, the first non-NaN element replaces it; an all-NaN vector returns index 0 and element 0.
REQ-022 +Inf and -Inf SHALL order normally; denormals SHALL be compared by bit pattern, with no flush to zero.
REQ-023 valid_i while ready_o is low SHALL be ignored; the in-flight vector SHALL not be disturbed.
REQ-024 No accept SHALL occur in the DONE cycle; the earliest next accept is the cycle after valid_o.
REQ-025 Back-to-back throughput SHALL be one vector per NUM/LANES + 2 cycles.

Reset
REQ-026 rstn low SHALL force IDLE, ready_o=1, valid_o=0, class_o=0, max_o=0, and clear the group counter and best registers immediately.
REQ-027 Reset asserted mid-SCAN SHALL abort the scan with no valid_o pulse; after rstn rises, the first accept SHALL behave as from power-up.

Structure
REQ-028 Shared package dense_pkg SHALL hold the FSM state enum, FP32 field-width constants (sign 1, exponent 8, mantissa 23), and an fp32 NaN-detect function.
REQ-029 One sub-module, fp32_gt, SHALL implement the combinational strict greater-than per REQ-020/021 (inputs a, b; output a_gt_b); it SHALL be instantiated LANES times as a chained compare.

Verification
REQ-030 NUM=8, LANES=2, element k = k+0.1 (0x3DCCCCCD for 0.1): accept -> valid_o 5 cycles later, class_o=7, max_o=0x40E33333 (7.1).
REQ-031 All elements = 2.0 (0x40000000) -> class_o=0 (tie keeps lowest index).
REQ-032 Element 3 = NaN (0x7FC00000), element 5 = +Inf (0x7F800000), others -1.0 -> class_o=5, max_o=0x7F800000.
REQ-033 Elements all negative, element 6 = -0.5 as the largest -> class_o=6; separately, element 0 = -0.0 and element 2 = +0.0 with others negative -> class_o=0.
REQ-034 valid_i held high continuously with changing data -> a second accept occurs exactly NUM/LANES+2 cycles after the first, and in-flight results are unchanged.
REQ-035 rstn pulsed low two cycles into SCAN -> no valid_o pulse, all outputs read reset values; the next vector yields the correct class_o.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and FP32 helpers for the dense-layer argmax block.
package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  function automatic logic fp32_is_nan(input logic [FP_W-1:0] x);
    return (&x[FP_W-2 -: FP_EXP_W]) && (|x[FP_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict a > b on FP32 scores: NaN never wins, beats only NaN-best,
// signed zeros compare equal, everything else by IEEE total value order.
module fp32_gt
  import dense_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            a_gt_b
);

  logic a_nan;
  logic b_nan;
  logic both_zero;
  logic ord_gt;

  always_comb begin
    a_nan     = fp32_is_nan(a);
    b_nan     = fp32_is_nan(b);
    both_zero = (a[FP_W-2:0] == '0) && (b[FP_W-2:0] == '0);
    // Sign-magnitude: magnitude order flips when both operands are negative.
    unique case ({a[FP_W-1], b[FP_W-1]})
      2'b00:   ord_gt = a[FP_W-2:0] > b[FP_W-2:0];
      2'b01:   ord_gt = 1'b1;
      2'b10:   ord_gt = 1'b0;
      default: ord_gt = a[FP_W-2:0] < b[FP_W-2:0];
    endcase
    a_gt_b = !a_nan && (b_nan || (ord_gt && !both_zero));
  end

endmodule

// File: rtl/dense_argmax.sv
// Sequential argmax over a dense FP32 score vector, LANES elements per cycle.
// Handshake: a vector is taken when valid_i && ready_o; valid_o is a one-cycle result pulse with no back-pressure.
module dense_argmax
  import dense_pkg::*;
#(
  parameter int NUM        = 128,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  localparam int IDXW      = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_WIDTH*NUM-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [IDXW-1:0]           class_o,
  output logic [DATA_WIDTH-1:0]     max_o,
  output logic                      valid_o,
  output state_t                    dbg_state_o
);

  localparam int GROUPS = NUM / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  state_t                state_q, state_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [DATA_WIDTH-1:0] best_v_q, best_v_d;
  logic [IDXW-1:0]       best_i_q, best_i_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]       class_q, class_d;
  logic [DATA_WIDTH-1:0] data_q [NUM];
  logic                  accept;
  logic [DATA_WIDTH-1:0] scan_v;
  logic [IDXW-1:0]       scan_i;

  assign accept = (state_q == ST_IDLE) && valid_i;

  // Lane l sees the running best after lanes 0..l-1, preserving ascending-index tie order.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] in_v, out_v, cand_v;
    logic [IDXW-1:0]       in_i, out_i, cand_i;
    logic                  cand_gt;

    if (l == 0) begin : g_first
      assign in_v = best_v_q;
      assign in_i = best_i_q;
    end else begin : g_next
      assign in_v = g_lane[l-1].out_v;
      assign in_i = g_lane[l-1].out_i;
    end

    assign cand_i = IDXW'(grp_q) * IDXW'(LANES) + IDXW'(l);
    assign cand_v = data_q[cand_i];

    fp32_gt u_gt (
      .a      (cand_v),
      .b      (in_v),
      .a_gt_b (cand_gt)
    );

    assign out_v = cand_gt ? cand_v : in_v;
    assign out_i = cand_gt ? cand_i : in_i;
  end

  assign scan_v = g_lane[LANES-1].out_v;
  assign scan_i = g_lane[LANES-1].out_i;

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    best_v_d = best_v_q;
    best_i_d = best_i_q;
    max_d    = max_q;
    class_d  = class_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d  = ST_SCAN;
          grp_d    = '0;
          best_v_d = data_i[DATA_WIDTH-1:0];
          best_i_d = '0;
        end
      end
      ST_SCAN: begin
        best_v_d = scan_v;
        best_i_d = scan_i;
        grp_d    = grp_q + 1'b1;
        if (grp_q == GW'(GROUPS - 1)) begin
          state_d = ST_DONE;
          max_d   = scan_v;
          class_d = scan_i;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      best_v_q <= '0;
      best_i_q <= '0;
      max_q    <= '0;
      class_q  <= '0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      best_v_q <= best_v_d;
      best_i_q <= best_i_d;
      max_q    <= max_d;
      class_q  <= class_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM; k++) data_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM; k++) data_q[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign valid_o     = (state_q == ST_DONE);
  assign class_o     = class_q;
  assign max_o       = max_q;
  assign dbg_state_o = state_q;

endmodule
